// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store control stage: size codes, FSM states,
// byte-lane mask and alignment helpers.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            SZ_B:    m = 4'b0001 << off;
            SZ_H:    m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Size code 3 is never legal, so it counts as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'd3) || ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational lane steering: shifts store data into its byte lanes and
// extracts/extends load data from a RAM word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;
    logic        sign_b;
    logic        sign_h;

    assign lane_wdata = wdata << {offset, 3'b000};
    assign shifted    = rdata >> {offset, 3'b000};
    assign sign_b     = ~is_unsigned & shifted[7];
    assign sign_h     = ~is_unsigned & shifted[15];

    always_comb begin
        load_data = shifted;
        case (size)
            SZ_B:    load_data = {{24{sign_b}}, shifted[7:0]};
            SZ_H:    load_data = {{16{sign_h}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage: accepts one request, performs a single-cycle
// word-aligned RAM access, and returns an aligned/extended response.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wen,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [MW-1:0] ram_mask,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    lsu_state_e    state;
    lsu_state_e    next_state;

    logic          wen_q;
    logic [1:0]    off_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic          err_q;
    logic [DW-1:0] rdata_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_wdata_q;

    logic [1:0]    align_off;
    logic [DW-1:0] lane_wdata;
    logic [DW-1:0] load_data;
    logic          misaligned;

    // In IDLE the aligner shifts incoming store data; in ACCESS it extracts load data.
    assign align_off  = (state == ST_IDLE) ? req_addr[1:0] : off_q;
    assign misaligned = is_misaligned(req_size, req_addr[1:0]);

    lsu_align u_align (
        .offset      (align_off),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (req_wdata),
        .rdata       (ram_rdata),
        .lane_wdata  (lane_wdata),
        .load_data   (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        ram_we     = 1'b0;
        ram_mask   = '0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = misaligned ? ST_RESP : ST_ACCESS;
            end
            ST_ACCESS: begin
                ram_we     = wen_q;
                ram_mask   = {{(MW-4){1'b0}}, lane_mask(size_q, off_q)};
                next_state = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // ram_addr/ram_wdata are registered at accept so they never toggle outside ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q       <= 1'b0;
            off_q       <= 2'd0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        wen_q   <= req_wen;
                        off_q   <= req_addr[1:0];
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        err_q   <= misaligned;
                        rdata_q <= '0;
                        if (!misaligned) begin
                            ram_addr_q  <= {req_addr[AW-1:2], 2'b00};
                            ram_wdata_q <= lane_wdata;
                        end
                    end
                end
                ST_ACCESS: rdata_q <= wen_q ? '0 : load_data;
                default: ;
            endcase
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl: stores, signed/unsigned loads,
// misaligned rejects, backpressure and asynchronous reset during a store.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [7:0]  ram_mask;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int n_cmp;
    int n_err;

    lsu_ctrl #(.AW(32), .DW(32), .MW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_mask     (ram_mask),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full transaction with resp_ready high; all expected values given by the caller.
    task automatic do_req(input string name, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                          input logic [31:0] rdata, input logic exp_err,
                          input logic [31:0] exp_rdata, input logic [7:0] exp_mask,
                          input logic [31:0] exp_wdata);
        @(negedge clk);
        req_valid    = 1'b1;
        req_wen      = wen;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        ram_rdata    = rdata;
        resp_ready   = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        if (!exp_err) begin
            check({name, ".acc_we"},    {31'd0, ram_we}, {31'd0, wen});
            check({name, ".acc_addr"},  ram_addr, {addr[31:2], 2'b00});
            check({name, ".acc_mask"},  {24'd0, ram_mask}, {24'd0, exp_mask});
            check({name, ".acc_wdata"}, ram_wdata, exp_wdata);
            check({name, ".acc_rvld"},  {31'd0, resp_valid}, 32'd0);
            check({name, ".acc_rdy"},   {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        check({name, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
        check({name, ".resp_rdata"}, resp_rdata, exp_rdata);
        check({name, ".resp_err"},   {31'd0, resp_err}, {31'd0, exp_err});
        check({name, ".resp_we"},    {31'd0, ram_we}, 32'd0);
        check({name, ".resp_mask"},  {24'd0, ram_mask}, 32'd0);
        @(negedge clk);
        check({name, ".idle_rdy"},   {31'd0, req_ready}, 32'd1);
        check({name, ".idle_rvld"},  {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_wen      = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        resp_ready   = 1'b1;
        ram_rdata    = 32'd0;

        repeat (2) @(negedge clk);
        check("rst.req_ready",  {31'd0, req_ready}, 32'd1);
        check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.resp_err",   {31'd0, resp_err}, 32'd0);
        check("rst.ram_we",     {31'd0, ram_we}, 32'd0);
        check("rst.ram_mask",   {24'd0, ram_mask}, 32'd0);
        check("rst.ram_addr",   ram_addr, 32'd0);
        check("rst.ram_wdata",  ram_wdata, 32'd0);
        rst = 1'b0;

        //       name     wen   addr          wdata         sz    uns   ram_rdata     err   exp_rdata     mask   exp_wdata
        do_req("st_b",  1'b1, 32'h8000_0003, 32'h0000_00AB, 2'd0, 1'b0, 32'h0,        1'b0, 32'h0,        8'h08, 32'hAB00_0000);
        do_req("st_h",  1'b1, 32'h8000_0002, 32'h0000_BEEF, 2'd1, 1'b0, 32'h0,        1'b0, 32'h0,        8'h0C, 32'hBEEF_0000);
        do_req("ld_hs", 1'b0, 32'h8000_0002, 32'h0,         2'd1, 1'b0, 32'h8001_1234, 1'b0, 32'hFFFF_8001, 8'h0C, 32'h0);
        do_req("ld_hu", 1'b0, 32'h8000_0002, 32'h0,         2'd1, 1'b1, 32'h8001_1234, 1'b0, 32'h0000_8001, 8'h0C, 32'h0);
        do_req("ld_bs", 1'b0, 32'h8000_0001, 32'h0,         2'd0, 1'b0, 32'h0000_F100, 1'b0, 32'hFFFF_FFF1, 8'h02, 32'h0);
        do_req("ld_w",  1'b0, 32'h8000_0010, 32'h0,         2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 8'h0F, 32'h0);
        do_req("mis_w", 1'b0, 32'h8000_0002, 32'h0,         2'd2, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0,        8'h00, 32'h0);
        do_req("mis_s3",1'b0, 32'h8000_0000, 32'h0,         2'd3, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0,        8'h00, 32'h0);

        // Backpressure: response held while req_valid stays high with a new request.
        @(negedge clk);
        resp_ready   = 1'b0;
        req_valid    = 1'b1;
        req_wen      = 1'b0;
        req_addr     = 32'h8000_0002;
        req_size     = 2'd1;
        req_unsigned = 1'b0;
        ram_rdata    = 32'h8001_1234;
        @(negedge clk);
        req_addr  = 32'h8000_0004;
        req_size  = 2'd2;
        @(negedge clk);
        ram_rdata = 32'h1122_3344;
        for (int i = 0; i < 5; i++) begin
            check("bp.resp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp.resp_rdata", resp_rdata, 32'hFFFF_8001);
            check("bp.req_ready",  {31'd0, req_ready}, 32'd0);
            check("bp.ram_mask",   {24'd0, ram_mask}, 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp.rel_ready", {31'd0, req_ready}, 32'd1);
        check("bp.rel_rvld",  {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp.next_mask", {24'd0, ram_mask}, 32'h0F);
        check("bp.next_addr", ram_addr, 32'h8000_0004);
        check("bp.next_rdy",  {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("bp.next_rdata", resp_rdata, 32'h1122_3344);
        check("bp.next_rvld",  {31'd0, resp_valid}, 32'd1);
        @(negedge clk);

        // Asynchronous reset in the middle of a store's ACCESS cycle.
        req_valid    = 1'b1;
        req_wen      = 1'b1;
        req_addr     = 32'h8000_0008;
        req_wdata    = 32'h1234_5678;
        req_size     = 2'd2;
        @(posedge clk);
        #2;
        check("ar.we_before", {31'd0, ram_we}, 32'd1);
        #1;
        rst       = 1'b1;
        req_valid = 1'b0;
        #1;
        check("ar.we_after",   {31'd0, ram_we}, 32'd0);
        check("ar.mask_after", {24'd0, ram_mask}, 32'd0);
        check("ar.req_ready",  {31'd0, req_ready}, 32'd1);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ar.no_resp", {31'd0, resp_valid}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
